// File: rtl/npc_exu_datapath.sv
// npc RV32 execute slice: 32x32 regfile, one-hot ALU, funct3 decoder.
// Define NPC_RF_BYPASS_EN for write-through read forwarding.
module npc_exu_datapath #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [10:0]     alu_op,
    output logic [XLEN-1:0] alu_result,
    input  logic [2:0]      funct3,
    output logic [7:0]      funct3_oh
);

    logic [XLEN-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wen && waddr != '0) begin
            r_regs[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(
        input logic [AW-1:0] addr
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (reset && addr != '0) begin
`ifdef NPC_RF_BYPASS_EN
            if (wen && addr == waddr) begin
                v = wdata;
            end else begin
                v = r_regs[addr];
            end
`else
            v = r_regs[addr];
`endif
        end
        return v;
    endfunction

    always_comb begin
        rdata1 = rf_read(raddr1);
        rdata2 = rf_read(raddr2);
    end

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_add;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sra;
    logic [XLEN-1:0] w_slt;
    logic [XLEN-1:0] w_sltu;

    assign w_shamt = src2[4:0];
    assign w_add   = src1 + src2;
    assign w_sub   = src1 - src2;
    assign w_sll   = src1 << w_shamt;
    assign w_srl   = src1 >> w_shamt;
    assign w_sra   = $signed(src1) >>> w_shamt;
    assign w_slt   = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
    assign w_sltu  = {{(XLEN-1){1'b0}}, src1 < src2};

    // AND-OR mux: multiple selects OR together, no select yields zero
    always_comb begin
        alu_result = ({XLEN{alu_op[0]}}  & w_add)
                   | ({XLEN{alu_op[1]}}  & w_sub)
                   | ({XLEN{alu_op[2]}}  & (src1 & src2))
                   | ({XLEN{alu_op[3]}}  & (src1 | src2))
                   | ({XLEN{alu_op[4]}}  & (src1 ^ src2))
                   | ({XLEN{alu_op[5]}}  & w_sll)
                   | ({XLEN{alu_op[6]}}  & w_srl)
                   | ({XLEN{alu_op[7]}}  & w_sra)
                   | ({XLEN{alu_op[8]}}  & w_slt)
                   | ({XLEN{alu_op[9]}}  & w_sltu)
                   | ({XLEN{alu_op[10]}} & src2);
    end

    assign funct3_oh = 8'b1 << funct3;

endmodule

// File: tb/tb_npc_exu_datapath.sv
// Self-checking bench for npc_exu_datapath with a behavioural model.
// Honours NPC_RF_BYPASS_EN for read-during-write expectations.
module tb_npc_exu_datapath;

    logic        clk;
    logic        reset;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [10:0] alu_op;
    logic [31:0] alu_result;
    logic [2:0]  funct3;
    logic [7:0]  funct3_oh;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [32];

    npc_exu_datapath dut (
        .clk(clk), .reset(reset),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1),
        .raddr2(raddr2), .rdata2(rdata2),
        .src1(src1), .src2(src2),
        .alu_op(alu_op), .alu_result(alu_result),
        .funct3(funct3), .funct3_oh(funct3_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [10:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] t;
        int s;
        r = 0;
        s = int'(b % 32);
        for (int i = 0; i < 11; i++) begin
            if (op[i]) begin
                case (i)
                    0: t = a + b;
                    1: t = a + ~b + 1;
                    2: t = a & b;
                    3: t = a | b;
                    4: t = a ^ b;
                    5: t = a * (32'd1 << s);
                    6: t = a / (32'd1 << s);
                    7: t = (a / (32'd1 << s))
                         | (a[31] ? ~(32'hFFFFFFFF / (32'd1 << s)) : 32'd0);
                    8: t = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    9: t = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
                    default: t = b;
                endcase
                r = r | t;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 0) ? 32'd0 : model[a];
`ifdef NPC_RF_BYPASS_EN
        if (wen && waddr != 0 && a == waddr) v = wdata;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset && wen && waddr != 0) model[waddr] = wdata;
        @(negedge clk);
    endtask

    logic [31:0] exp_rdw;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        reset = 0; wen = 0; waddr = 0; wdata = 0;
        raddr1 = 0; raddr2 = 0; src1 = 0; src2 = 0;
        alu_op = 0; funct3 = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // T1: reset mid-cycle clears immediately
        wen = 1; waddr = 5; wdata = 32'h1234;
        tick();
        wen = 0; raddr1 = 5;
        #1 check("pre_reset_x5", rdata1, 32'h1234);
        #1 reset = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        #1 check("reset_async_x5", rdata1, 0);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            check("reset_rd1", rdata1, 0);
            check("reset_rd2", rdata2, 0);
        end
        wen = 1; waddr = 9; wdata = 32'hCAFE;
        tick();
        reset = 1; wen = 0; raddr1 = 9;
        #1 check("reset_write_ignored", rdata1, 0);

        // T2
        wen = 1; waddr = 3; wdata = 32'hDEADBEEF;
        tick();
        wen = 0; raddr1 = 3; raddr2 = 3;
        #1 check("wr_rd1", rdata1, 32'hDEADBEEF);
        check("wr_rd2", rdata2, 32'hDEADBEEF);

        // T3
        wen = 1; waddr = 0; wdata = 32'hFFFFFFFF;
        raddr1 = 0;
        #1 check("x0_bypass", rdata1, 0);
        tick();
        wen = 0;
        #1 check("x0_after", rdata1, 0);

        // T4
        wen = 1; waddr = 7; wdata = 32'h11;
        tick();
        wdata = 32'h22; raddr1 = 7;
`ifdef NPC_RF_BYPASS_EN
        exp_rdw = 32'h22;
`else
        exp_rdw = 32'h11;
`endif
        #1 check("rdw_before", rdata1, exp_rdw);
        tick();
        wen = 0;
        #1 check("rdw_after", rdata1, 32'h22);

        // T5
        src1 = 32'h80000000; src2 = 1;
        alu_op = 11'h001; #1 check("add", alu_result, 32'h80000001);
        alu_op = 11'h002; #1 check("sub", alu_result, 32'h7FFFFFFF);
        alu_op = 11'h100; #1 check("slt", alu_result, 1);
        alu_op = 11'h200; #1 check("sltu", alu_result, 0);
        alu_op = 11'h000; #1 check("none", alu_result, 0);
        src2 = 4;
        alu_op = 11'h080; #1 check("sra", alu_result, 32'hF8000000);
        alu_op = 11'h040; #1 check("srl", alu_result, 32'h08000000);
        alu_op = 11'h020; #1 check("sll", alu_result, 0);
        alu_op = 11'h400; #1 check("pass", alu_result, 4);

        // T6
        for (int i = 0; i < 8; i++) begin
            funct3 = 3'(i);
            #1 check("dec", {24'd0, funct3_oh}, 32'd1 << i);
        end

        // Random regfile traffic, ALU ops and decode
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wen    = 1'($urandom);
            waddr  = 5'($urandom);
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = 5'($urandom);
            src1   = $urandom;
            src2   = ($urandom_range(0, 3) == 0) ? src1 : $urandom;
            if ($urandom_range(0, 7) == 0)
                alu_op = 11'($urandom);
            else
                alu_op = 11'(32'd1 << $urandom_range(0, 11));
            funct3 = 3'($urandom);
            #1;
            check("rnd_rd1", rdata1, rd_ref(raddr1));
            check("rnd_rd2", rdata2, rd_ref(raddr2));
            check("rnd_alu", alu_result, alu_ref(alu_op, src1, src2));
            check("rnd_dec", {24'd0, funct3_oh}, 32'd1 << funct3);
            @(posedge clk);
            if (wen && waddr != 0) model[waddr] = wdata;
        end
        @(negedge clk);
        wen = 0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1 check("final_rd", rdata1, (i == 0) ? 32'd0 : model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
